// File: rtl/mips_mem_pkg.sv
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared width codes, FSM state encoding and alignment helper
//                for the MIPS MEM stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    // Access width codes carried on i_width (2'b10 behaves as a word)
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

    // MEM-stage transaction FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // True when the access width cannot be served at this byte offset
    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (width)
            W_BYTE:  bad = 1'b0;
            W_HALF:  bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane logic. Store side replicates the
//                store data across lanes and builds little-endian byte
//                enables; load side extracts the addressed byte/half and
//                sign- or zero-extends it. Lane logic assumes 4 byte lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mips_mem_pkg::*;
#(
    parameter int NB_DATA = 32
)
(
    input  logic [1:0]         addr_lo,
    input  logic [1:0]         width,
    input  logic               sign_flag,
    input  logic [NB_DATA-1:0] store_data,
    input  logic [NB_DATA-1:0] load_rdata,
    output logic [NB_DATA-1:0] store_wdata,
    output logic [3:0]         store_be,
    output logic [NB_DATA-1:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store path: lane replication and byte enables
    always_comb begin
        store_wdata = store_data;
        store_be    = 4'b1111;
        case (width)
            W_BYTE: begin
                store_wdata = {(NB_DATA/8){store_data[7:0]}};
                store_be    = 4'b0001 << addr_lo;
            end
            W_HALF: begin
                store_wdata = {(NB_DATA/16){store_data[15:0]}};
                store_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_wdata = store_data;
                store_be    = 4'b1111;
            end
        endcase
    end

    // Load path: lane select then extension; words pass straight through
    always_comb begin
        w_byte    = load_rdata[{addr_lo, 3'b000} +: 8];
        w_half    = load_rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data = load_rdata;
        case (width)
            W_BYTE:  load_data = {{(NB_DATA-8){sign_flag & w_byte[7]}}, w_byte};
            W_HALF:  load_data = {{(NB_DATA-16){sign_flag & w_half[15]}}, w_half};
            default: load_data = load_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access_stage.sv
// ============================================================================
//  Module      : memory_access_stage
//  Description : MIPS MEM stage. Issues one req/ack data-memory transaction
//                per load/store, stalls the pipeline until ack, then loads
//                the MEM/WB register. A halt during the ack cycle parks the
//                read word in a hold buffer until the halt is released.
//  Options     : MEM_MISALIGN_TRAP_EN - misaligned half/word accesses issue no
//                request, pulse o_misalign and suppress register writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_access_stage
    import mips_mem_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
)
(
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    output logic               o_dm_req,
    output logic               o_dm_we,
    output logic [NB_ADDR-1:0] o_dm_addr,
    output logic [3:0]         o_dm_be,
    output logic [NB_DATA-1:0] o_dm_wdata,
    input  logic               i_dm_ack,
    input  logic [NB_DATA-1:0] i_dm_rdata,
    output logic               o_stall,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_misalign
);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    // Latched transaction fields (stable for the whole REQ/HOLD window)
    logic [NB_ADDR-1:0] r_addr;
    logic               r_we;
    logic [3:0]         r_be;
    logic [NB_DATA-1:0] r_wdata;
    logic [1:0]         r_lo;
    logic [1:0]         r_width;
    logic               r_sign;
    logic               r_is_load;
    logic               r_mem2reg;
    logic               r_regwrite;
    logic [4:0]         r_write_reg;
    logic [NB_DATA-1:0] r_result;
    logic [NB_DATA-1:0] r_hold_rdata;

    logic               w_mem_op;
    logic               w_trap;
    logic               w_issue;
    logic               w_wb_direct;
    logic               w_wb_mem;
    logic               w_in_idle;
    logic [1:0]         w_al_lo;
    logic [1:0]         w_al_width;
    logic               w_al_sign;
    logic [NB_DATA-1:0] w_al_rdata;
    logic [NB_DATA-1:0] w_st_wdata;
    logic [3:0]         w_st_be;
    logic [NB_DATA-1:0] w_ld_data;

    assign w_mem_op  = i_memRead | i_memWrite;
    assign w_in_idle = (r_state == ST_IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_mem_op & is_misaligned(i_width, i_result[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    assign w_issue     = w_in_idle & ~i_halt & w_mem_op & ~w_trap;
    assign w_wb_direct = w_in_idle & ~i_halt & (~w_mem_op | w_trap);
    assign w_wb_mem    = ((r_state == ST_REQ)  & i_dm_ack & ~i_halt) |
                         ((r_state == ST_HOLD) & ~i_halt);

    // In IDLE the lane logic builds store lanes from live inputs; afterwards it
    // decodes the returned word using the latched offset/width/sign.
    assign w_al_lo    = w_in_idle ? i_result[1:0] : r_lo;
    assign w_al_width = w_in_idle ? i_width       : r_width;
    assign w_al_sign  = w_in_idle ? i_sign_flag   : r_sign;
    assign w_al_rdata = (r_state == ST_HOLD) ? r_hold_rdata : i_dm_rdata;

    mem_lane_align #(
        .NB_DATA     (NB_DATA)
    ) u_lane_align (
        .addr_lo     (w_al_lo),
        .width       (w_al_width),
        .sign_flag   (w_al_sign),
        .store_data  (i_data4Mem),
        .load_rdata  (w_al_rdata),
        .store_wdata (w_st_wdata),
        .store_be    (w_st_be),
        .load_data   (w_ld_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a started transaction only ends on ack or reset
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_issue)  w_next_state = ST_REQ;
            ST_REQ:  if (i_dm_ack) w_next_state = i_halt ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (!i_halt)  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: request strobe and pipeline stall
    always_comb begin
        o_dm_req = (r_state == ST_REQ);
        o_stall  = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: o_stall = w_issue;
                ST_REQ:  o_stall = ~(i_dm_ack & ~i_halt);
                ST_HOLD: o_stall = i_halt;
                default: o_stall = 1'b0;
            endcase
        end
    end

    // Capture the transaction fields at issue and park read data on a halted ack
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_lo         <= '0;
            r_width      <= '0;
            r_sign       <= 1'b0;
            r_is_load    <= 1'b0;
            r_mem2reg    <= 1'b0;
            r_regwrite   <= 1'b0;
            r_write_reg  <= '0;
            r_result     <= '0;
            r_hold_rdata <= '0;
        end else begin
            if (w_issue) begin
                r_addr      <= i_result[NB_ADDR+1:2];
                r_we        <= i_memWrite;
                r_be        <= w_st_be;
                r_wdata     <= w_st_wdata;
                r_lo        <= i_result[1:0];
                r_width     <= i_width;
                r_sign      <= i_sign_flag;
                r_is_load   <= ~i_memWrite;
                r_mem2reg   <= i_mem2reg;
                r_regwrite  <= i_regWrite;
                r_write_reg <= i_write_reg;
                r_result    <= i_result;
            end
            if ((r_state == ST_REQ) && i_dm_ack && i_halt) begin
                r_hold_rdata <= i_dm_rdata;
            end
        end
    end

    // MEM/WB register: direct load for non-memory ops, post-ack load otherwise
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_mem2reg   <= 1'b0;
            o_regWrite  <= 1'b0;
            o_write_reg <= '0;
            o_read_data <= '0;
            o_result    <= '0;
            o_misalign  <= 1'b0;
        end else begin
            o_misalign <= 1'b0;
            if (w_wb_direct) begin
                o_mem2reg   <= i_mem2reg;
                o_regWrite  <= i_regWrite & ~w_trap;
                o_write_reg <= i_write_reg;
                o_read_data <= '0;
                o_result    <= i_result;
                o_misalign  <= w_trap;
            end else if (w_wb_mem) begin
                o_mem2reg   <= r_mem2reg;
                o_regWrite  <= r_regwrite;
                o_write_reg <= r_write_reg;
                o_read_data <= r_is_load ? w_ld_data : '0;
                o_result    <= r_result;
            end
        end
    end

    assign o_dm_we    = r_we;
    assign o_dm_addr  = r_addr;
    assign o_dm_be    = r_be;
    assign o_dm_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_memory_access_stage.sv
// ============================================================================
//  Module      : tb_memory_access_stage
//  Description : Directed self-checking bench for memory_access_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        i_rst, i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic [4:0]  i_write_reg;
    logic [31:0] i_result, i_data4Mem;
    logic        o_dm_req, o_dm_we;
    logic [9:0]  o_dm_addr;
    logic [3:0]  o_dm_be;
    logic [31:0] o_dm_wdata;
    logic        i_dm_ack;
    logic [31:0] i_dm_rdata;
    logic        o_stall, o_mem2reg, o_regWrite;
    logic [4:0]  o_write_reg;
    logic [31:0] o_read_data, o_result;
    logic        o_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.NB_DATA(32), .NB_ADDR(10)) dut (
        .clk(clk), .i_rst(i_rst), .i_halt(i_halt), .i_mem2reg(i_mem2reg),
        .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_regWrite(i_regWrite),
        .i_width(i_width), .i_sign_flag(i_sign_flag), .i_write_reg(i_write_reg),
        .i_result(i_result), .i_data4Mem(i_data4Mem),
        .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
        .o_dm_be(o_dm_be), .o_dm_wdata(o_dm_wdata),
        .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
        .o_stall(o_stall), .o_mem2reg(o_mem2reg), .o_regWrite(o_regWrite),
        .o_write_reg(o_write_reg), .o_read_data(o_read_data),
        .o_result(o_result), .o_misalign(o_misalign)
    );

    task automatic set_idle();
        i_halt = 0; i_mem2reg = 0; i_memRead = 0; i_memWrite = 0; i_regWrite = 0;
        i_width = 2'b00; i_sign_flag = 0; i_write_reg = 0; i_result = 0;
        i_data4Mem = 0; i_dm_ack = 0; i_dm_rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drives one memory op, acks ack_delay cycles after the request appears,
    // and reports what the memory port showed. Returns just after the edge
    // that loaded MEM/WB.
    task automatic run_mem_op(input logic rd, input logic wr, input logic [1:0] wd,
                              input logic sg, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rdat, input logic rw, input logic [4:0] wreg,
                              input logic m2r, input int ack_delay,
                              output logic saw_req, output logic [9:0] q_addr,
                              output logic [3:0] q_be, output logic [31:0] q_wdata,
                              output logic q_we, output int stall_cycles);
        logic done;
        done = 0; saw_req = 0; stall_cycles = 0;
        q_addr = 0; q_be = 0; q_wdata = 0; q_we = 0;
        i_memRead = rd; i_memWrite = wr; i_width = wd; i_sign_flag = sg;
        i_result = a; i_data4Mem = d; i_dm_rdata = rdat; i_regWrite = rw;
        i_write_reg = wreg; i_mem2reg = m2r;
        for (int c = 0; c < 20 && !done; c++) begin
            i_dm_ack = (c == 1 + ack_delay);
            @(negedge clk);
            if (o_dm_req && !saw_req) begin
                saw_req = 1; q_addr = o_dm_addr; q_be = o_dm_be;
                q_wdata = o_dm_wdata; q_we = o_dm_we;
            end
            if (o_stall) stall_cycles++;
            else done = 1;
            tick();
        end
        set_idle();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL op_timeout: stall still %0d after 20 cycles, required 0", o_stall);
        end
    endtask

    task automatic test_reset();
        i_rst = 1; set_idle();
        tick(); tick();
        i_rst = 0;
        @(negedge clk);
        checks++;
        if ({o_dm_req, o_dm_we, o_dm_addr, o_dm_be, o_dm_wdata, o_stall, o_mem2reg,
             o_regWrite, o_write_reg, o_read_data, o_result, o_misalign} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wdata=%h stall=%b rd=%h res=%h, required all 0",
                     o_dm_req, o_dm_we, o_dm_addr, o_dm_be, o_dm_wdata, o_stall, o_read_data, o_result);
        end
        tick();
    endtask

    task automatic test_store_word();
        logic sr, we; logic [9:0] ad; logic [3:0] be; logic [31:0] wd; int st;
        run_mem_op(0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 0, 0, 5'd0, 0, 3, sr, ad, be, wd, we, st);
        checks++; if (sr !== 1'b1) begin errors++; $display("FAIL sw_req: got %b required 1", sr); end
        checks++; if (ad !== 10'd4) begin errors++; $display("FAIL sw_addr: got %0d required 4", ad); end
        checks++; if (be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b required 1111", be); end
        checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h required deadbeef", wd); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b required 1", we); end
        checks++; if (st != 4) begin errors++; $display("FAIL sw_stall_cycles: got %0d required 4", st); end
        checks++; if (o_regWrite !== 1'b0) begin errors++; $display("FAIL sw_regwrite: got %b required 0", o_regWrite); end
        checks++; if (o_result !== 32'h10) begin errors++; $display("FAIL sw_result: got %h required 10", o_result); end
        checks++; if (o_read_data !== 32'h0) begin errors++; $display("FAIL sw_read_data: got %h required 0", o_read_data); end
    endtask

    task automatic test_load_byte();
        logic sr, we; logic [9:0] ad; logic [3:0] be; logic [31:0] wd; int st;
        run_mem_op(1, 0, 2'b00, 1, 32'h13, 0, 32'h80000000, 1, 5'd5, 1, 1, sr, ad, be, wd, we, st);
        checks++; if (be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b required 1000", be); end
        checks++; if (ad !== 10'd4 || we !== 1'b0) begin errors++; $display("FAIL lb_addr_we: got %0d/%b required 4/0", ad, we); end
        checks++; if (o_read_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h required ffffff80", o_read_data); end
        checks++; if ({o_regWrite, o_mem2reg, o_write_reg} !== {1'b1, 1'b1, 5'd5}) begin
            errors++; $display("FAIL lb_ctrl: got rw=%b m2r=%b wr=%0d required 1/1/5", o_regWrite, o_mem2reg, o_write_reg); end
        checks++; if (st != 2) begin errors++; $display("FAIL lb_stall_cycles: got %0d required 2", st); end
        run_mem_op(1, 0, 2'b00, 0, 32'h13, 0, 32'h80000000, 1, 5'd5, 1, 0, sr, ad, be, wd, we, st);
        checks++; if (o_read_data !== 32'h00000080) begin errors++; $display("FAIL lbu_unsigned: got %h required 00000080", o_read_data); end
        checks++; if (st != 1) begin errors++; $display("FAIL lbu_min_latency: got %0d stall cycles required 1", st); end
        run_mem_op(1, 0, 2'b00, 1, 32'h11, 0, 32'h00007F00, 1, 5'd6, 1, 0, sr, ad, be, wd, we, st);
        checks++; if (o_read_data !== 32'h0000007F || be !== 4'b0010) begin
            errors++; $display("FAIL lb_lane1: got %h be=%b required 0000007f be=0010", o_read_data, be); end
    endtask

    task automatic test_half();
        logic sr, we; logic [9:0] ad; logic [3:0] be; logic [31:0] wd; int st;
        run_mem_op(0, 1, 2'b01, 0, 32'h06, 32'h00001234, 0, 0, 5'd0, 0, 0, sr, ad, be, wd, we, st);
        checks++; if (wd !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h required 12341234", wd); end
        checks++; if (be !== 4'b1100 || ad !== 10'd1) begin errors++; $display("FAIL sh_be_addr: got %b/%0d required 1100/1", be, ad); end
        run_mem_op(1, 0, 2'b01, 0, 32'h06, 0, 32'hABCD0000, 1, 5'd2, 1, 2, sr, ad, be, wd, we, st);
        checks++; if (o_read_data !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_data: got %h required 0000abcd", o_read_data); end
        run_mem_op(1, 0, 2'b01, 1, 32'h04, 0, 32'h0000ABCD, 1, 5'd2, 1, 0, sr, ad, be, wd, we, st);
        checks++; if (o_read_data !== 32'hFFFFABCD || be !== 4'b0011) begin
            errors++; $display("FAIL lh_signed_low: got %h be=%b required ffffabcd be=0011", o_read_data, be); end
    endtask

    task automatic test_alu_op();
        i_regWrite = 1; i_write_reg = 5'd7; i_result = 32'h55; i_dm_ack = 1;
        @(negedge clk);
        checks++; if (o_stall !== 1'b0 || o_dm_req !== 1'b0) begin
            errors++; $display("FAIL alu_no_stall: got stall=%b req=%b required 0/0", o_stall, o_dm_req); end
        tick();
        checks++; if ({o_result, o_write_reg, o_regWrite, o_read_data} !== {32'h55, 5'd7, 1'b1, 32'h0}) begin
            errors++; $display("FAIL alu_passthrough: got res=%h wr=%0d rw=%b rd=%h required 55/7/1/0",
                               o_result, o_write_reg, o_regWrite, o_read_data); end
        i_dm_ack = 0; i_halt = 1; i_result = 32'h66; i_write_reg = 5'd9;
        tick();
        checks++; if (o_result !== 32'h55 || o_write_reg !== 5'd7) begin
            errors++; $display("FAIL idle_halt_freeze: got res=%h wr=%0d required 55/7", o_result, o_write_reg); end
        set_idle();
    endtask

    task automatic test_halt_hold();
        i_memRead = 1; i_width = 2'b11; i_result = 32'h20; i_dm_rdata = 32'h11223344;
        i_regWrite = 1; i_write_reg = 5'd3; i_mem2reg = 1;
        @(negedge clk);
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL hold_issue_stall: got %b required 1", o_stall); end
        tick();
        i_halt = 1; i_dm_ack = 1;
        @(negedge clk);
        checks++; if (o_dm_req !== 1'b1 || o_stall !== 1'b1) begin
            errors++; $display("FAIL hold_ack_halted: got req=%b stall=%b required 1/1", o_dm_req, o_stall); end
        tick();
        i_dm_ack = 0; i_dm_rdata = 32'hFFFF0000;
        @(negedge clk);
        checks++; if (o_stall !== 1'b1 || o_dm_req !== 1'b0 || o_result !== 32'h55 || o_read_data !== 32'h0) begin
            errors++; $display("FAIL hold_frozen: got stall=%b req=%b res=%h rd=%h required 1/0/55/0",
                               o_stall, o_dm_req, o_result, o_read_data); end
        tick();
        i_halt = 0;
        @(negedge clk);
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hold_release_stall: got %b required 0", o_stall); end
        tick();
        set_idle();
        checks++; if (o_read_data !== 32'h11223344 || o_result !== 32'h20 || o_write_reg !== 5'd3) begin
            errors++; $display("FAIL hold_release_data: got rd=%h res=%h wr=%0d required 11223344/20/3",
                               o_read_data, o_result, o_write_reg); end
    endtask

    task automatic test_reset_mid_req();
        i_memRead = 1; i_width = 2'b11; i_result = 32'h40; i_regWrite = 1;
        i_write_reg = 5'd8; i_dm_rdata = 32'h12345678;
        tick();
        i_rst = 1;
        @(negedge clk);
        checks++; if (o_dm_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b required 1", o_dm_req); end
        tick();
        i_rst = 0; set_idle(); i_dm_ack = 1; i_dm_rdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if ({o_dm_req, o_dm_we, o_dm_addr, o_dm_be, o_dm_wdata, o_stall, o_mem2reg,
             o_regWrite, o_write_reg, o_read_data, o_result, o_misalign} !== '0) begin
            errors++;
            $display("FAIL rst_mid_req: got req=%b addr=%h be=%b stall=%b rd=%h res=%h rw=%b required all 0",
                     o_dm_req, o_dm_addr, o_dm_be, o_stall, o_read_data, o_result, o_regWrite);
        end
        tick();
        i_dm_ack = 0;
        @(negedge clk);
        checks++; if (o_read_data !== 32'h0 || o_dm_req !== 1'b0 || o_regWrite !== 1'b0) begin
            errors++; $display("FAIL late_ack_ignored: got rd=%h req=%b rw=%b required 0/0/0", o_read_data, o_dm_req, o_regWrite); end
        tick();
    endtask

    task automatic test_misalign();
        logic sr, we; logic [9:0] ad; logic [3:0] be; logic [31:0] wd; int st;
        run_mem_op(1, 0, 2'b11, 0, 32'h02, 0, 32'hCAFEF00D, 1, 5'd4, 1, 0, sr, ad, be, wd, we, st);
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (sr !== 1'b0 || st != 0) begin errors++; $display("FAIL trap_no_req: got req=%b stall_cycles=%0d required 0/0", sr, st); end
        checks++; if (o_misalign !== 1'b1 || o_regWrite !== 1'b0) begin
            errors++; $display("FAIL trap_pulse: got mis=%b rw=%b required 1/0", o_misalign, o_regWrite); end
`else
        checks++; if (sr !== 1'b1 || ad !== 10'd0 || be !== 4'b1111) begin
            errors++; $display("FAIL lw_lowbits_ignored: got req=%b addr=%0d be=%b required 1/0/1111", sr, ad, be); end
        checks++; if (o_read_data !== 32'hCAFEF00D || o_regWrite !== 1'b1 || o_misalign !== 1'b0) begin
            errors++; $display("FAIL lw_unaligned_load: got rd=%h rw=%b mis=%b required cafef00d/1/0", o_read_data, o_regWrite, o_misalign); end
`endif
        tick();
        checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL misalign_one_cycle: got %b required 0", o_misalign); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1; set_idle();
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_alu_op();
        test_halt_hold();
        test_reset_mid_req();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
